// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone-to-SDRAM bridge and the SoC address decode.
package wb_bridge_pkg;

  // Bridge sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_ACK    = 2'd3
  } bridge_state_e;

  // Default SDRAM window in Wishbone word addresses; LIMIT is exclusive
  localparam logic [23:0] BRIDGE_BASE  = 24'h100004;
  localparam logic [23:0] BRIDGE_LIMIT = 24'hffe000;

endpackage

// File: rtl/wb_sdram_bridge.sv
// Wishbone classic-cycle slave that forwards single transfers to the SDRAM
// controller's req/cack/read_ready handshake, with abort and timeout handling.
// wb_ack/wb_err are registered, so they appear in the first IDLE cycle after
// the transfer completes; a fresh request is not accepted while either is high,
// which keeps a master that still holds stb during the response from being
// accepted twice.
module wb_sdram_bridge
  import wb_bridge_pkg::*;
#(
  parameter logic [23:0] BASE    = BRIDGE_BASE,
  parameter logic [23:0] LIMIT   = BRIDGE_LIMIT,
  parameter int          TIMEOUT = 255,
  parameter int          TW      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [23:0] wb_adr,
  input  logic [15:0] wb_i_dat,
  input  logic [1:0]  wb_sel,
  output logic [15:0] wb_o_dat,
  output logic        wb_ack,
  output logic        wb_err,
  output logic [23:0] c_addr,
  output logic [15:0] c_data_in,
  output logic [1:0]  c_addr_sel,
  output logic        c_read_req,
  output logic        c_write_req,
  input  logic [31:0] c_data_out,
  input  logic        c_cack,
  input  logic        c_read_ready,
  input  logic        c_busy
);

  bridge_state_e state_q, state_d;

  logic [23:0]   addr_q, addr_d;
  logic [15:0]   wdat_q, wdat_d;
  logic [1:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          rd_req_q, rd_req_d;
  logic          wr_req_q, wr_req_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [15:0]   rdat_q, rdat_d;
  logic          abort_q, abort_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic hit;
  logic accept;
  logic busy;
  logic tmo_hit;
  logic abort_now;

  // c_busy is informational only and the upper read half is never used
  logic unused_ok;
  assign unused_ok = ^{c_busy, c_data_out[31:16]};

  assign hit       = wb_cyc & wb_stb & (wb_adr >= BASE) & (wb_adr < LIMIT);
  assign accept    = (state_q == ST_IDLE) & hit & ~ack_q & ~err_q;
  assign busy      = (state_q == ST_REQ) | (state_q == ST_RDWAIT);
  assign tmo_hit   = (TIMEOUT != 0) && busy && (tmo_q == TW'(TIMEOUT));
  // Master walking away in REQ/RDWAIT counts as an abort from that cycle on
  assign abort_now = abort_q | (busy & ~wb_cyc);

  // State and datapath registers, all returned to zero by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdat_q   <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdat_q   <= '0;
      abort_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdat_q   <= rdat_d;
      abort_q  <= abort_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state: timeout takes priority over a late controller response
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (tmo_hit)     state_d = ST_IDLE;
        else if (c_cack) state_d = (we_q || c_read_ready) ? ST_ACK : ST_RDWAIT;
      end
      ST_RDWAIT: begin
        if (tmo_hit)           state_d = ST_IDLE;
        else if (c_read_ready) state_d = ST_ACK;
      end
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values: request levels, captures, responses
  always_comb begin
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    rdat_d   = rdat_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    tmo_d    = busy ? tmo_q + TW'(1) : '0;
    abort_d  = (state_d == ST_IDLE) ? 1'b0 : abort_now;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d   = wb_adr;
          wdat_d   = wb_i_dat;
          sel_d    = wb_sel;
          we_d     = wb_we;
          rd_req_d = ~wb_we;
          wr_req_d = wb_we;
        end
      end
      ST_REQ: begin
        if (tmo_hit) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          err_d    = ~abort_now;
        end else if (c_cack) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          if (!we_q && c_read_ready) rdat_d = c_data_out[15:0];
        end
      end
      ST_RDWAIT: begin
        if (tmo_hit)           err_d  = ~abort_now;
        else if (c_read_ready) rdat_d = c_data_out[15:0];
      end
      ST_ACK:  ack_d = ~abort_q;
      default: ;
    endcase
  end

  assign wb_o_dat    = rdat_q;
  assign wb_ack      = ack_q;
  assign wb_err      = err_q;
  assign c_addr      = addr_q;
  assign c_data_in   = wdat_q;
  assign c_addr_sel  = sel_q;
  assign c_read_req  = rd_req_q;
  assign c_write_req = wr_req_q;

endmodule
